// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port between NUM_REQ
// valid/ready burst sources. An owner keeps the port until its last beat or
// MAX_BURST beats, whichever comes first. Protocol problems are kept in
// sticky status bits.
module async_fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          wr_clk_i,
    input  logic                          wr_rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_overflow_i,
    input  logic                          clr_err_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          overflow_err_o,
    output logic                          trunc_err_o
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  grant_id_q, grant_id_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            overflow_err_q, overflow_err_d;
    logic            trunc_err_q, trunc_err_d;

    logic                  any_valid;
    logic [IdW-1:0]        winner;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  can_write;
    logic                  accept;
    logic                  max_beat;
    logic                  trunc_set;

    // Pick the first valid requester scanning cyclically upward from rr_ptr+1.
    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] cand;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        cand      = '0;
        // Descending offset so the nearest candidate is written last and wins.
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand = IdW'(idx);
            if (req_valid_i[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Select the current owner's stream signals.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IdW'(i)) begin
                owner_valid = req_valid_i[i];
                owner_last  = req_last_i[i];
                owner_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready is combinational from fifo_full so a full FIFO is never written.
    always_comb begin
        busy_o    = (state_q == StGrant);
        can_write = busy_o & ~fifo_full_i;
        accept    = can_write & owner_valid;
        max_beat  = (beat_cnt_q == CntW'(MAX_BURST - 1));
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = can_write & (grant_id_q == IdW'(i));
        end
        fifo_wr_en_o   = accept;
        fifo_wr_data_o = owner_data;
        grant_id_o     = grant_id_q;
        overflow_err_o = overflow_err_q;
        trunc_err_o    = trunc_err_q;
    end

    // Next-state: arbitration in idle, beat counting and release in grant.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        trunc_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (owner_last || max_beat) begin
                        state_d  = StIdle;
                        rr_ptr_d = grant_id_q;
                        // A last beat landing exactly on MAX_BURST is a clean release.
                        trunc_set = max_beat & ~owner_last;
                    end
                end
            end
        endcase
        // Clear wins over a same-cycle set.
        overflow_err_d = clr_err_i ? 1'b0 : (overflow_err_q | fifo_overflow_i);
        trunc_err_d    = clr_err_i ? 1'b0 : (trunc_err_q | trunc_set);
    end

    // State and status registers with asynchronous reset.
    always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
        if (wr_rst_i) begin
            state_q        <= StIdle;
            rr_ptr_q       <= IdW'(NUM_REQ - 1);
            grant_id_q     <= '0;
            beat_cnt_q     <= '0;
            overflow_err_q <= 1'b0;
            trunc_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            beat_cnt_q     <= beat_cnt_d;
            overflow_err_q <= overflow_err_d;
            trunc_err_q    <= trunc_err_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter (4 requesters, MAX_BURST = 4).
module tb_async_fifo_wr_arbiter;

    logic        wr_clk;
    logic        wr_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_overflow;
    logic        clr_err;
    logic [1:0]  grant_id;
    logic        busy;
    logic        overflow_err;
    logic        trunc_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         n_before;

    async_fifo_wr_arbiter #(
        .DATA_WIDTH(8),
        .NUM_REQ   (4),
        .MAX_BURST (4)
    ) dut (
        .wr_clk_i       (wr_clk),
        .wr_rst_i       (wr_rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_full_i    (fifo_full),
        .fifo_overflow_i(fifo_overflow),
        .clr_err_i      (clr_err),
        .grant_id_o     (grant_id),
        .busy_o         (busy),
        .overflow_err_o (overflow_err),
        .trunc_err_o    (trunc_err)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Record every beat the FIFO would store.
    always @(posedge wr_clk) begin
        if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        tick();
        tick();
        wr_rst = 1'b0;
    endtask

    initial begin
        wr_rst        = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        fifo_full     = 1'b0;
        fifo_overflow = 1'b0;
        clr_err       = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_trunc", trunc_err, 0);
        wr_rst = 1'b0;

        // Single requester: 3 beats A1..A3
        req_valid = 4'b0001;
        req_data[7:0] = 8'hA1;
        #1;
        chk("single_idle_wr_en", fifo_wr_en, 0);
        tick();
        chk("single_busy", busy, 1);
        chk("single_wr_en1", fifo_wr_en, 1);
        chk("single_ready", req_ready, 4'b0001);
        chk("single_data1", fifo_wr_data, 8'hA1);
        tick();
        req_data[7:0] = 8'hA2;
        #1;
        chk("single_wr_en2", fifo_wr_en, 1);
        tick();
        req_data[7:0] = 8'hA3;
        req_last[0]   = 1'b1;
        #1;
        chk("single_wr_en3", fifo_wr_en, 1);
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("single_busy_end", busy, 0);
        chk("single_wr_en_end", fifo_wr_en, 0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);

        // Round-robin from reset: single-beat bursts from all four
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h13121110;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rr_grant", grant_id, k % 4);
            chk("rr_busy", busy, 1);
            chk("rr_data", fifo_wr_data, 8'h10 + (k % 4));
            exp_q.push_back(8'(8'h10 + (k % 4)));
            tick();
            chk("rr_idle", busy, 0);
        end

        // Burst lock: req0 4-beat burst (last on MAX_BURST beat), req1 waiting
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        req_data  = 32'h0000C1B0;
        tick();
        chk("lock_grant0", grant_id, 0);
        for (int b = 1; b <= 4; b++) begin
            req_data[7:0] = 8'(8'hB0 + b);
            req_last[0]   = (b == 4);
            #1;
            chk("lock_ready", req_ready, 4'b0001);
            chk("lock_data", fifo_wr_data, 8'hB0 + b);
            exp_q.push_back(8'(8'hB0 + b));
            tick();
        end
        req_valid[0] = 1'b0;
        #1;
        chk("lock_released", busy, 0);
        chk("lock_no_trunc", trunc_err, 0);
        tick();
        chk("lock_grant1", grant_id, 1);
        chk("lock_ready1", req_ready, 4'b0010);
        chk("lock_data1", fifo_wr_data, 8'hC1);
        exp_q.push_back(8'hC1);
        tick();
        req_valid = '0;
        req_last  = '0;

        // Backpressure: full for 4 cycles in the middle of a req2 burst
        req_valid = 4'b0100;
        req_data  = 32'h00D10000;
        tick();
        chk("bp_grant", grant_id, 2);
        chk("bp_wr_en1", fifo_wr_en, 1);
        tick();
        req_data[23:16] = 8'hD2;
        fifo_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_full_wr_en", fifo_wr_en, 0);
            chk("bp_full_ready", req_ready, 0);
            chk("bp_full_busy", busy, 1);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("bp_resume_wr_en", fifo_wr_en, 1);
        chk("bp_resume_data", fifo_wr_data, 8'hD2);
        tick();
        req_data[23:16] = 8'hD3;
        req_last[2]     = 1'b1;
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("bp_busy_end", busy, 0);
        chk("bp_ovf", overflow_err, 0);
        exp_q.push_back(8'hD1);
        exp_q.push_back(8'hD2);
        exp_q.push_back(8'hD3);

        // Truncation: req2 streams without last, req3 waits
        req_valid = 4'b0100;
        req_data  = 32'h33000000;
        req_last  = 4'b1000;
        tick();
        chk("tr_grant2", grant_id, 2);
        req_valid = 4'b1100;
        for (int b = 1; b <= 4; b++) begin
            req_data[23:16] = 8'(8'hE0 + b);
            #1;
            chk("tr_trunc_low", trunc_err, 0);
            chk("tr_wr_en", fifo_wr_en, 1);
            exp_q.push_back(8'(8'hE0 + b));
            tick();
        end
        chk("tr_trunc_set", trunc_err, 1);
        chk("tr_released", busy, 0);
        tick();
        chk("tr_grant3", grant_id, 3);
        chk("tr_data3", fifo_wr_data, 8'h33);
        exp_q.push_back(8'h33);
        tick();
        req_valid = '0;
        req_last  = '0;
        clr_err   = 1'b1;
        #1;
        chk("tr_trunc_held", trunc_err, 1);
        tick();
        clr_err = 1'b0;
        #1;
        chk("tr_trunc_clr", trunc_err, 0);

        // Overflow sticky bit, clear has priority over a same-cycle set
        fifo_overflow = 1'b1;
        clr_err       = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        clr_err       = 1'b0;
        #1;
        chk("ovf_clr_wins", overflow_err, 0);
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        tick();
        chk("ovf_sticky", overflow_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        #1;
        chk("ovf_clr", overflow_err, 0);

        // Reset during beat 2 of a req1 burst
        req_valid = 4'b0010;
        req_data  = 32'h0000F100;
        tick();
        chk("mr_grant1", grant_id, 1);
        tick();
        exp_q.push_back(8'hF1);
        req_data[15:8] = 8'hF2;
        #1;
        chk("mr_beat2_wr_en", fifo_wr_en, 1);
        n_before = got_q.size();
        wr_rst   = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_wr_en", fifo_wr_en, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_grant", grant_id, 0);
        tick();
        tick();
        wr_rst    = 1'b0;
        req_valid = 4'b0011;
        req_data  = 32'h0000F25A;
        tick();
        chk("mr_restart_grant", grant_id, 0);
        chk("mr_restart_busy", busy, 1);
        chk("mr_restart_data", fifo_wr_data, 8'h5A);
        chk("mr_no_write", got_q.size(), n_before);

        // Everything written to the FIFO, in order
        chk("log_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("log_data", got_q[i], exp_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
